frv_mem_arbiter: RTL and testbench

- Shares one memory bus between the instruction-fetch port (i) and the load/store port (d) of the core.
- Selects one requester per request, forwards its request to the bus, and records the owner of each accepted request in an in-order ID FIFO.
- Routes each bus response back to the owner of that request.
- Sits between the fetch/memory pipeline stages and the single external memory interface.

---
 rtl/frv_mem_arbiter_pkg.sv | 34 +++
 rtl/frv_arb_id_fifo.sv | 79 +++++++
 rtl/frv_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_frv_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_mem_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory arbiter.
package frv_mem_arbiter_pkg;

    typedef enum logic {
        ARB_ID_I = 1'b0,
        ARB_ID_D = 1'b1
    } arb_id_e;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    localparam int OUTSTANDING_MIN = 1;
    localparam int OUTSTANDING_MAX = 4;

    // Out-of-range depths are pulled into the supported window.
    function automatic int outstanding_clamp(input int n);
        int r;
        if (n < OUTSTANDING_MIN) begin
            r = OUTSTANDING_MIN;
        end else if (n > OUTSTANDING_MAX) begin
            r = OUTSTANDING_MAX;
        end else begin
            r = n;
        end
        return r;
    endfunction

    function automatic arb_id_e arb_other(input arb_id_e id);
        return (id == ARB_ID_I) ? ARB_ID_D : ARB_ID_I;
    endfunction

endpackage

// File: rtl/frv_arb_id_fifo.sv
// In-order FIFO of request owner IDs; the head names who receives the next bus response.
module frv_arb_id_fifo
    import frv_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    g_clk,
    input  logic    g_resetn,
    input  logic    push_i,
    input  arb_id_e push_id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output arb_id_e head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    arb_id_e         mem_q [DEPTH];
    arb_id_e         mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok_s;
    logic            pop_ok_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == {CW{1'b0}});
    assign head_o  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        push_ok_s = push_i && !full_o;
        pop_ok_s  = pop_i && !empty_o;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            mem_q    <= '{default: ARB_ID_I};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/frv_mem_arbiter.sv
// Shares one memory bus between instruction fetch (i) and load/store (d),
// returning in-order responses to whichever port issued each request.
module frv_mem_arbiter
    import frv_mem_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int ROUND_ROBIN = 1,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            i_req,
    output logic            i_gnt,
    input  logic            i_wen,
    input  logic [DW/8-1:0] i_strb,
    input  logic [AW-1:0]   i_addr,
    input  logic [DW-1:0]   i_wdata,
    output logic            i_recv,
    input  logic            i_ack,
    output logic [DW-1:0]   i_rdata,
    output logic            i_error,
    input  logic            d_req,
    output logic            d_gnt,
    input  logic            d_wen,
    input  logic [DW/8-1:0] d_strb,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_recv,
    input  logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            d_error,
    output logic            m_req,
    input  logic            m_gnt,
    output logic            m_wen,
    output logic [DW/8-1:0] m_strb,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_recv,
    output logic            m_ack,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_error
);

    localparam int DEPTH = outstanding_clamp(OUTSTANDING);

    lock_state_e lock_q, lock_d;
    arb_id_e     lock_id_q, lock_id_d;
    arb_id_e     last_grant_q, last_grant_d;
    arb_id_e     sel_id_s;
    arb_id_e     head_id_s;
    logic        sel_req_s;
    logic        xfer_s;
    logic        pop_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;

    // A locked selection wins over any fresh arbitration so bus fields stay stable.
    always_comb begin
        sel_id_s = ARB_ID_I;
        if (lock_q == LOCK_HELD) begin
            sel_id_s = lock_id_q;
        end else if (i_req && d_req) begin
            if (ROUND_ROBIN != 0) begin
                sel_id_s = arb_other(last_grant_q);
            end else begin
                sel_id_s = ARB_ID_D;
            end
        end else if (d_req) begin
            sel_id_s = ARB_ID_D;
        end else begin
            sel_id_s = ARB_ID_I;
        end
    end

    // Bus request, grants and request field mux
    always_comb begin
        sel_req_s = (sel_id_s == ARB_ID_D) ? d_req : i_req;
        m_req     = g_resetn && sel_req_s && !fifo_full_s;
        xfer_s    = m_req && m_gnt;
        i_gnt     = xfer_s && (sel_id_s == ARB_ID_I);
        d_gnt     = xfer_s && (sel_id_s == ARB_ID_D);
        m_wen     = 1'b0;
        m_strb    = {(DW/8){1'b0}};
        m_addr    = {AW{1'b0}};
        m_wdata   = {DW{1'b0}};
        if (m_req) begin
            case (sel_id_s)
                ARB_ID_D: begin
                    m_wen   = d_wen;
                    m_strb  = d_strb;
                    m_addr  = d_addr;
                    m_wdata = d_wdata;
                end
                ARB_ID_I: begin
                    m_wen   = i_wen;
                    m_strb  = i_strb;
                    m_addr  = i_addr;
                    m_wdata = i_wdata;
                end
                default: begin
                    m_wen   = 1'b0;
                    m_strb  = {(DW/8){1'b0}};
                    m_addr  = {AW{1'b0}};
                    m_wdata = {DW{1'b0}};
                end
            endcase
        end else begin
            m_wen = 1'b0;
        end
    end

    // Lock and round-robin history next-state
    always_comb begin
        lock_d       = LOCK_IDLE;
        lock_id_d    = lock_id_q;
        last_grant_d = last_grant_q;
        case (lock_q)
            LOCK_IDLE: begin
                if (m_req && !m_gnt) begin
                    lock_d    = LOCK_HELD;
                    lock_id_d = sel_id_s;
                end else begin
                    lock_d = LOCK_IDLE;
                end
            end
            LOCK_HELD: begin
                // A requester that withdraws without a grant releases the lock.
                if (m_req && !m_gnt) begin
                    lock_d = LOCK_HELD;
                end else begin
                    lock_d = LOCK_IDLE;
                end
            end
            default: lock_d = LOCK_IDLE;
        endcase
        if (xfer_s) begin
            last_grant_d = sel_id_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Lock state register
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            lock_q       <= LOCK_IDLE;
            lock_id_q    <= ARB_ID_I;
            last_grant_q <= ARB_ID_I;
        end else begin
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Responses go to the FIFO head; with nothing outstanding they are acked and dropped.
    always_comb begin
        i_recv  = 1'b0;
        i_rdata = {DW{1'b0}};
        i_error = 1'b0;
        d_recv  = 1'b0;
        d_rdata = {DW{1'b0}};
        d_error = 1'b0;
        m_ack   = 1'b0;
        if (!g_resetn) begin
            m_ack = 1'b0;
        end else if (fifo_empty_s) begin
            m_ack = m_recv;
        end else begin
            case (head_id_s)
                ARB_ID_I: begin
                    i_recv  = m_recv;
                    i_rdata = m_rdata;
                    i_error = m_error;
                    m_ack   = i_ack;
                end
                ARB_ID_D: begin
                    d_recv  = m_recv;
                    d_rdata = m_rdata;
                    d_error = m_error;
                    m_ack   = d_ack;
                end
                default: m_ack = m_recv;
            endcase
        end
        pop_s = m_recv && m_ack && !fifo_empty_s;
    end

    frv_arb_id_fifo #(
        .DEPTH(DEPTH)
    ) u_id_fifo (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .push_i   (xfer_s),
        .push_id_i(sel_id_s),
        .pop_i    (pop_s),
        .full_o   (fifo_full_s),
        .empty_o  (fifo_empty_s),
        .head_o   (head_id_s)
    );

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Directed bench for frv_mem_arbiter: queue-based reference model checked every
// cycle plus literal expectations at the key points of each scenario.
module tb_frv_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req, i_wen, i_ack, d_req, d_wen, d_ack;
    logic [3:0]  i_strb, d_strb;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        m_gnt, m_recv, m_error;
    logic [31:0] m_rdata;

    logic        i_gnt, i_recv, i_error, d_gnt, d_recv, d_error;
    logic [31:0] i_rdata, d_rdata;
    logic        m_req, m_wen, m_ack;
    logic [3:0]  m_strb;
    logic [31:0] m_addr, m_wdata;

    logic        b_i_gnt, b_i_recv, b_i_error, b_d_gnt, b_d_recv, b_d_error;
    logic [31:0] b_i_rdata, b_d_rdata;
    logic        b_m_req, b_m_wen, b_m_ack;
    logic [3:0]  b_m_strb;
    logic [31:0] b_m_addr, b_m_wdata;

    int checks   = 0;
    int failures = 0;

    frv_mem_arbiter #(.OUTSTANDING(2), .ROUND_ROBIN(1), .AW(32), .DW(32)) dut (
        .g_clk(clk), .g_resetn(rst_n),
        .i_req(i_req), .i_gnt(i_gnt), .i_wen(i_wen), .i_strb(i_strb), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_recv(i_recv), .i_ack(i_ack), .i_rdata(i_rdata), .i_error(i_error),
        .d_req(d_req), .d_gnt(d_gnt), .d_wen(d_wen), .d_strb(d_strb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_recv(d_recv), .d_ack(d_ack), .d_rdata(d_rdata), .d_error(d_error),
        .m_req(m_req), .m_gnt(m_gnt), .m_wen(m_wen), .m_strb(m_strb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_recv(m_recv), .m_ack(m_ack), .m_rdata(m_rdata), .m_error(m_error)
    );

    frv_mem_arbiter #(.OUTSTANDING(2), .ROUND_ROBIN(0), .AW(32), .DW(32)) dut_fixed (
        .g_clk(clk), .g_resetn(rst_n),
        .i_req(i_req), .i_gnt(b_i_gnt), .i_wen(i_wen), .i_strb(i_strb), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_recv(b_i_recv), .i_ack(i_ack), .i_rdata(b_i_rdata), .i_error(b_i_error),
        .d_req(d_req), .d_gnt(b_d_gnt), .d_wen(d_wen), .d_strb(d_strb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_recv(b_d_recv), .d_ack(d_ack), .d_rdata(b_d_rdata), .d_error(b_d_error),
        .m_req(b_m_req), .m_gnt(m_gnt), .m_wen(b_m_wen), .m_strb(b_m_strb), .m_addr(b_m_addr),
        .m_wdata(b_m_wdata), .m_recv(m_recv), .m_ack(b_m_ack), .m_rdata(m_rdata), .m_error(m_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; i_wen = 1'b0; i_ack = 1'b0; i_strb = 4'h0; i_addr = 32'h0; i_wdata = 32'h0;
        d_req = 1'b0; d_wen = 1'b0; d_ack = 1'b0; d_strb = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        m_gnt = 1'b0; m_recv = 1'b0; m_error = 1'b0; m_rdata = 32'h0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model (instance dut): owner queue, round-robin history, pending lock. 1 = d, 0 = i.
    bit mq[$];
    bit ml_last;
    bit ml_locked;
    bit ml_lock_id;

    always @(negedge clk) begin : model_cmp
        bit          sel, sreq, e_mreq, xfer, e_mack, tgt, has;
        logic        e_wen;
        logic [3:0]  e_strb;
        logic [31:0] e_addr, e_wdata;
        if (!rst_n) begin
            chk("mdl_rst_out", {m_req, i_gnt, d_gnt, i_recv, d_recv, m_ack}, 64'd0);
            mq.delete();
            ml_last = 1'b0; ml_locked = 1'b0; ml_lock_id = 1'b0;
        end else begin
            if (ml_locked) sel = ml_lock_id;
            else if (i_req && d_req) sel = !ml_last;
            else sel = d_req;
            sreq   = sel ? d_req : i_req;
            e_mreq = sreq && (mq.size() < 2);
            xfer   = e_mreq && m_gnt;
            e_wen   = e_mreq ? (sel ? d_wen : i_wen) : 1'b0;
            e_strb  = e_mreq ? (sel ? d_strb : i_strb) : 4'h0;
            e_addr  = e_mreq ? (sel ? d_addr : i_addr) : 32'h0;
            e_wdata = e_mreq ? (sel ? d_wdata : i_wdata) : 32'h0;
            has = (mq.size() > 0);
            tgt = has ? mq[0] : 1'b0;
            e_mack = has ? (tgt ? d_ack : i_ack) : m_recv;
            chk("mdl_m_req", m_req, e_mreq);
            chk("mdl_gnt", {d_gnt, i_gnt}, {xfer && sel, xfer && !sel});
            chk("mdl_fields", {m_wen, m_strb, m_addr, m_wdata}, {e_wen, e_strb, e_addr, e_wdata});
            chk("mdl_recv", {d_recv, i_recv}, {has && tgt && m_recv, has && !tgt && m_recv});
            chk("mdl_m_ack", m_ack, e_mack);
            chk("mdl_i_resp", {i_error, i_rdata}, (has && !tgt) ? {m_error, m_rdata} : 33'd0);
            chk("mdl_d_resp", {d_error, d_rdata}, (has && tgt) ? {m_error, m_rdata} : 33'd0);
            if (m_recv && e_mack && has) void'(mq.pop_front());
            if (xfer) begin
                mq.push_back(sel);
                ml_last = sel;
            end
            ml_locked  = e_mreq && !m_gnt;
            ml_lock_id = sel;
        end
    end

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        idle_inputs();
        i_req = 1'b1;
        tick();
        chk("rst_m_req", m_req, 0);
        chk("rst_fixed_all", |{b_i_gnt, b_i_recv, b_i_error, b_d_gnt, b_d_recv, b_d_error, b_i_rdata,
                                b_d_rdata, b_m_req, b_m_wen, b_m_ack, b_m_strb, b_m_addr, b_m_wdata}, 0);
        tick();
        rst_n = 1'b1;
        idle_inputs();
        tick();

        // single i read
        i_req = 1'b1; i_addr = 32'h100; i_strb = 4'hF; m_gnt = 1'b1;
        settle();
        chk("iread_i_gnt", i_gnt, 1);
        chk("iread_d_gnt", d_gnt, 0);
        chk("iread_addr", m_addr, 32'h100);
        tick();
        idle_inputs(); m_recv = 1'b1; m_rdata = 32'hDEADBEEF; i_ack = 1'b1;
        settle();
        chk("iread_i_recv", i_recv, 1);
        chk("iread_rdata", i_rdata, 32'hDEADBEEF);
        chk("iread_d_recv", d_recv, 0);
        chk("iread_m_ack", m_ack, 1);
        tick();

        // contention, with responses draining so the FIFO never fills
        idle_inputs();
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h104; d_addr = 32'h204; m_gnt = 1'b1;
        i_ack = 1'b1; d_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_recv = (k > 0);
            m_rdata = 32'h1000 + k;
            settle();
            chk("rr_grant", {d_gnt, i_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
            chk("fixed_grant", {b_d_gnt, b_i_gnt}, 2'b10);
            tick();
        end
        idle_inputs(); m_recv = 1'b1; i_ack = 1'b1; d_ack = 1'b1;
        settle();
        chk("rr_drain_i", i_recv, 1);
        tick();

        // lock holds i against a later d request
        idle_inputs(); i_req = 1'b1; i_addr = 32'h200;
        settle();
        chk("lock_c0_addr", m_addr, 32'h200);
        tick();
        d_req = 1'b1; d_addr = 32'h300;
        settle();
        chk("lock_c1_addr", m_addr, 32'h200);
        tick();
        settle();
        chk("lock_c2_addr", m_addr, 32'h200);
        tick();
        m_gnt = 1'b1;
        settle();
        chk("lock_c3_gnt", {d_gnt, i_gnt}, 2'b01);
        tick();
        i_req = 1'b0;
        settle();
        chk("lock_c4_gnt", {d_gnt, i_gnt}, 2'b10);
        chk("lock_c4_addr", m_addr, 32'h300);
        tick();

        // full: two outstanding (i, d)
        idle_inputs(); i_req = 1'b1; i_addr = 32'h400; m_gnt = 1'b1;
        settle();
        chk("full_m_req", m_req, 0);
        chk("full_i_gnt", i_gnt, 0);
        tick();
        m_recv = 1'b1; i_ack = 1'b1; m_rdata = 32'h11111111;
        settle();
        chk("full_pop_recv", i_recv, 1);
        chk("full_same_cycle", m_req, 0);
        tick();
        m_recv = 1'b0;
        settle();
        chk("full_freed_req", m_req, 1);
        chk("full_freed_gnt", i_gnt, 1);
        tick();
        idle_inputs(); m_recv = 1'b1; i_ack = 1'b1; d_ack = 1'b1;
        settle();
        chk("drain_d", {d_recv, i_recv}, 2'b10);
        tick();
        settle();
        chk("drain_i", {d_recv, i_recv}, 2'b01);
        tick();

        // ordering with head-of-line blocking
        idle_inputs(); i_req = 1'b1; i_addr = 32'h500; m_gnt = 1'b1;
        settle();
        chk("ord_i_gnt", i_gnt, 1);
        tick();
        idle_inputs(); d_req = 1'b1; d_addr = 32'h600; d_wen = 1'b1; d_wdata = 32'hCAFEF00D;
        d_strb = 4'h3; m_gnt = 1'b1;
        settle();
        chk("ord_d_gnt", d_gnt, 1);
        chk("ord_wr_fields", {m_wen, m_strb, m_wdata}, {1'b1, 4'h3, 32'hCAFEF00D});
        tick();
        idle_inputs(); m_recv = 1'b1; m_error = 1'b0; d_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("hol_i_recv", i_recv, 1);
            chk("hol_m_ack", m_ack, 0);
            chk("hol_d_recv", d_recv, 0);
            tick();
        end
        i_ack = 1'b1;
        settle();
        chk("ord_first", {i_recv, i_error, m_ack}, 3'b101);
        tick();
        m_error = 1'b1;
        settle();
        chk("ord_second", {d_recv, d_error, i_recv}, 3'b110);
        tick();

        // reset with one request in flight
        idle_inputs(); i_req = 1'b1; i_addr = 32'h700; m_gnt = 1'b1;
        settle();
        chk("rst_pre_gnt", i_gnt, 1);
        tick();
        idle_inputs(); m_recv = 1'b1; i_ack = 1'b1; rst_n = 1'b0;
        #1;
        chk("rst_now_out", {m_ack, i_recv, m_req, i_gnt}, 4'b0000);
        tick();
        idle_inputs();
        tick();
        rst_n = 1'b1;
        settle();
        tick();
        m_recv = 1'b1;
        settle();
        chk("unexp_m_ack", m_ack, 1);
        chk("unexp_recv", {d_recv, i_recv}, 2'b00);
        tick();
        idle_inputs();
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
